// File: rtl/game_state_controller.sv
// Game-state FSM: arbitrates maskable collision sources, tracks lives and enforces a
// timed respawn window before returning to play or ending the game.
module game_state_controller #(
    parameter int unsigned NUM_SOURCES    = 4,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned RESPAWN_CYCLES = 8,
    localparam int unsigned LW = $clog2(LIVES + 1),
    localparam int unsigned CW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_SOURCES-1:0] collision,
    input  logic [NUM_SOURCES-1:0] collisionMask,
    output logic                   playing,
    output logic                   respawning,
    output logic                   gameOver,
    output logic [LW-1:0]          livesLeft,
    output logic                   hitPulse,
    output logic [CW-1:0]          hitCause
);

    localparam int unsigned TW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [LW-1:0] LivesInit = LW'(LIVES);
    localparam logic [TW-1:0] TimerInit = TW'(RESPAWN_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPlaying, StRespawn, StGameOver} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cause_q, cause_d;
    logic            pulse_q, pulse_d;
    logic            playing_q, respawning_q, gameover_q;
    logic [NUM_SOURCES-1:0] hits;
    logic            hit;
    logic [CW-1:0]   cause_hit;

    assign hits = collision & collisionMask;
    assign hit  = |hits;

    // Lowest enabled source wins: scan downward so the last assignment is the lowest index.
    always_comb begin
        cause_hit = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (hits[i]) cause_hit = CW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        timer_d = timer_q;
        cause_d = cause_q;
        pulse_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPlaying;
                    lives_d = LivesInit;
                end
            end
            StPlaying: begin
                if (hit) begin
                    pulse_d = 1'b1;
                    cause_d = cause_hit;
                    if (lives_q > LW'(1)) begin
                        state_d = StRespawn;
                        lives_d = lives_q - LW'(1);
                        timer_d = TimerInit;
                    end else begin
                        state_d = StGameOver;
                        lives_d = '0;
                    end
                end
            end
            StRespawn: begin
                if (timer_q == '0) state_d = StPlaying;
                else               timer_d = timer_q - TW'(1);
            end
            StGameOver: begin
                // Restart takes precedence over any collision this cycle.
                if (start) begin
                    state_d = StPlaying;
                    lives_d = LivesInit;
                    cause_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            lives_q      <= LivesInit;
            timer_q      <= '0;
            cause_q      <= '0;
            pulse_q      <= 1'b0;
            playing_q    <= 1'b0;
            respawning_q <= 1'b0;
            gameover_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            cause_q      <= cause_d;
            pulse_q      <= pulse_d;
            playing_q    <= (state_d == StPlaying);
            respawning_q <= (state_d == StRespawn);
            gameover_q   <= (state_d == StGameOver);
        end
    end

    assign playing    = playing_q;
    assign respawning = respawning_q;
    assign gameOver   = gameover_q;
    assign livesLeft  = lives_q;
    assign hitPulse   = pulse_q;
    assign hitCause   = cause_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: each vector queues its expected post-edge
// outputs; a monitor pops one entry after every edge and compares.
module tb_game_state_controller;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] collision;
    logic [3:0] collisionMask;
    logic       playing;
    logic       respawning;
    logic       gameOver;
    logic [1:0] livesLeft;
    logic       hitPulse;
    logic [1:0] hitCause;

    game_state_controller #(
        .NUM_SOURCES    (4),
        .LIVES          (3),
        .RESPAWN_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .collision     (collision),
        .collisionMask (collisionMask),
        .playing       (playing),
        .respawning    (respawning),
        .gameOver      (gameOver),
        .livesLeft     (livesLeft),
        .hitPulse      (hitPulse),
        .hitCause      (hitCause)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [7:0] exp; // {playing, respawning, gameOver, livesLeft, hitPulse, hitCause}
    } vec_t;

    vec_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Drive one cycle of stimulus and queue the outputs required after the next edge.
    task automatic drv(input string tag, input logic rs, input logic st,
                       input logic [3:0] col, input logic [3:0] msk,
                       input logic p, input logic r, input logic g,
                       input logic [1:0] lv, input logic hp, input logic [1:0] hc);
        vec_t v;
        @(negedge clock);
        reset         = rs;
        start         = st;
        collision     = col;
        collisionMask = msk;
        v.tag = tag;
        v.exp = {p, r, g, lv, hp, hc};
        q.push_back(v);
    endtask

    always begin
        vec_t       v;
        logic [7:0] act;
        @(posedge clock);
        #2;
        if (q.size() > 0) begin
            v   = q.pop_front();
            act = {playing, respawning, gameOver, livesLeft, hitPulse, hitCause};
            n_vec++;
            if (act !== v.exp) begin
                n_miss++;
                $display("FAIL %s: got p/r/g/lives/pulse/cause=%b required %b", v.tag, act, v.exp);
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; collision = 4'b0; collisionMask = 4'b1111;

        // Reset and IDLE: collisions ignored
        drv("reset0",   0, 0, 4'b0000, 4'b1111, 0, 0, 0, 2'd3, 0, 2'd0);
        drv("reset1",   0, 0, 4'b0000, 4'b1111, 0, 0, 0, 2'd3, 0, 2'd0);
        drv("idle_ign", 1, 0, 4'b1111, 4'b1111, 0, 0, 0, 2'd3, 0, 2'd0);
        drv("idle_ign", 1, 0, 4'b1111, 4'b1111, 0, 0, 0, 2'd3, 0, 2'd0);

        // Start, then a hit on source 2 and the full 8-cycle respawn window
        drv("start",    1, 1, 4'b0000, 4'b1111, 1, 0, 0, 2'd3, 0, 2'd0);
        drv("hit_src2", 1, 0, 4'b0100, 4'b1111, 0, 1, 0, 2'd2, 1, 2'd2);
        for (int i = 0; i < 7; i++)
            drv("respawn1", 1, 0, 4'b0000, 4'b1111, 0, 1, 0, 2'd2, 0, 2'd2);
        drv("resp1_end", 1, 0, 4'b0000, 4'b1111, 1, 0, 0, 2'd2, 0, 2'd2);
        drv("start_ign", 1, 1, 4'b0000, 4'b1111, 1, 0, 0, 2'd2, 0, 2'd2);

        // Masking: only source 3 enabled, then all masked off
        drv("mask_src3", 1, 0, 4'b1010, 4'b1000, 0, 1, 0, 2'd1, 1, 2'd3);
        for (int i = 0; i < 7; i++)
            drv("respawn2", 1, 0, 4'b1111, 4'b1111, 0, 1, 0, 2'd1, 0, 2'd3);
        drv("resp2_end", 1, 0, 4'b0000, 4'b1111, 1, 0, 0, 2'd1, 0, 2'd3);
        drv("mask_all",  1, 0, 4'b1010, 4'b0000, 1, 0, 0, 2'd1, 0, 2'd3);
        drv("mask_all",  1, 0, 4'b1111, 4'b0000, 1, 0, 0, 2'd1, 0, 2'd3);

        // Last life lost; game over holds against collisions and keeps hitCause
        drv("fatal_hit", 1, 0, 4'b0010, 4'b1111, 0, 0, 1, 2'd0, 1, 2'd1);
        drv("go_hold",   1, 0, 4'b1111, 4'b1111, 0, 0, 1, 2'd0, 0, 2'd1);
        drv("go_hold",   1, 0, 4'b1111, 4'b1111, 0, 0, 1, 2'd0, 0, 2'd1);

        // Restart wins over a same-cycle collision
        drv("restart",   1, 1, 4'b0001, 4'b1111, 1, 0, 0, 2'd3, 0, 2'd0);

        // Collision held continuously: a hit every 9 cycles, lowest index of 1100 is 2
        drv("held_hit1", 1, 0, 4'b1100, 4'b1111, 0, 1, 0, 2'd2, 1, 2'd2);
        for (int i = 0; i < 7; i++)
            drv("held_resp1", 1, 0, 4'b1100, 4'b1111, 0, 1, 0, 2'd2, 0, 2'd2);
        drv("held_play1", 1, 0, 4'b1100, 4'b1111, 1, 0, 0, 2'd2, 0, 2'd2);
        drv("held_hit2",  1, 0, 4'b1100, 4'b1111, 0, 1, 0, 2'd1, 1, 2'd2);
        for (int i = 0; i < 7; i++)
            drv("held_resp2", 1, 0, 4'b1100, 4'b1111, 0, 1, 0, 2'd1, 0, 2'd2);
        drv("held_play2", 1, 0, 4'b1100, 4'b1111, 1, 0, 0, 2'd1, 0, 2'd2);
        drv("held_fatal", 1, 0, 4'b1100, 4'b1111, 0, 0, 1, 2'd0, 1, 2'd2);
        drv("held_go",    1, 0, 4'b1100, 4'b1111, 0, 0, 1, 2'd0, 0, 2'd2);

        // Reset in the middle of a respawn countdown
        drv("restart2",  1, 1, 4'b0000, 4'b1111, 1, 0, 0, 2'd3, 0, 2'd0);
        drv("hit_src3",  1, 0, 4'b1000, 4'b1111, 0, 1, 0, 2'd2, 1, 2'd3);
        for (int i = 0; i < 3; i++)
            drv("respawn3", 1, 0, 4'b0000, 4'b1111, 0, 1, 0, 2'd2, 0, 2'd3);
        drv("mid_reset", 0, 0, 4'b1111, 4'b1111, 0, 0, 0, 2'd3, 0, 2'd0);
        drv("post_rst",  1, 0, 4'b1111, 4'b1111, 0, 0, 0, 2'd3, 0, 2'd0);
        drv("start3",    1, 1, 4'b0000, 4'b1111, 1, 0, 0, 2'd3, 0, 2'd0);
        drv("play3",     1, 0, 4'b0000, 4'b1111, 1, 0, 0, 2'd3, 0, 2'd0);

        @(negedge clock);
        @(negedge clock);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
